xor_gate: RTL and testbench
===========================

XOR_GATE -- requirements
Module: xor_gate

Interface
REQ-001 Parameter CNT_W, default 8: width of ones_cnt, legal range 2..32.
REQ-002 Port order SHALL be out, input1, input2, clk, rst_n, clr, out_q, toggle_q, ones_cnt, so a positional hookup of only the first three ports yields a working 2-input XOR.
REQ-003 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 out  output  1  combinational XOR of input1 and input2.
REQ-006 input1  input  1  first XOR operand.
REQ-007 input2  input  1  second XOR operand.
REQ-008 clr  input  1  synchronous clear of ones_cnt, active-high.
REQ-009 out_q  output  1  out registered once.
REQ-010 toggle_q  output  1  registered flag: out differed from out_q at the last edge.
REQ-011 ones_cnt  output  CNT_W  saturating count of edges sampling out=1.

Function
REQ-012 out SHALL equal input1 XOR input2 with zero clock latency and no storage: 0,0->0; 0,1->1; 1,0->1; 1,1->0.
REQ-013 out SHALL be independent of clk, rst_n and clr, and SHALL be valid even when those ports are unconnected.
REQ-014 out SHALL settle within the same simulation time step as any input change, with no added delay.
REQ-015 X or Z on input1 or input2 SHALL propagate as X on out; no masking.
REQ-016 At each rising clk edge with rst_n=1, out_q SHALL load out, giving exactly 1 cycle of latency.
REQ-017 At each rising clk edge with rst_n=1, toggle_q SHALL load (out XOR out_q), using the pre-edge out_q.
REQ-018 At each rising clk edge with rst_n=1 and clr=1, ones_cnt SHALL load 0; clr SHALL take priority over increment.
REQ-019 At each rising clk edge with rst_n=1, clr=0 and out=1, ones_cnt SHALL increment by 1 unless it already equals 2^CNT_W-1, in which case it SHALL hold (saturate, never wrap).
REQ-020 At each rising clk edge with rst_n=1, clr=0 and out=0, ones_cnt SHALL hold.
REQ-021 Input changes coincident with a clk edge: the registers SHALL sample the pre-edge value of out.

Reset
REQ-022 When rst_n=0, out_q, toggle_q and ones_cnt SHALL clear to 0 immediately, without waiting for clk, and SHALL hold there while rst_n=0.
REQ-023 Reset assertion mid-count SHALL discard the count.
REQ-024 After rst_n rises, the first update SHALL occur at the first rising clk edge with rst_n=1.
REQ-025 Reset SHALL NOT affect out, which keeps tracking input1 XOR input2 during reset.

Verification
REQ-026 Truth table, no clock: apply (0,0),(0,1),(1,0),(1,1), 20 time units each -> out = 0,1,1,0, updating at each step time.
REQ-027 Latency: after reset, set input1=1, input2=0 and apply 1 clk edge -> out_q=1, toggle_q=1; after a 2nd edge -> out_q=1, toggle_q=0.
REQ-028 Counting: hold out=1 for 5 edges from reset -> ones_cnt=5; pulse clr for 1 edge with out=1 -> ones_cnt=0.
REQ-029 Saturation, CNT_W=2: hold out=1 for 6 edges -> ones_cnt=3 after the 3rd edge and remains 3.
REQ-030 Asynchronous reset: ones_cnt=4, out_q=1, then drop rst_n between edges -> all three registers read 0 at once while out still equals input1 XOR input2.
REQ-031 X handling: input1=1'bx, input2=0 -> out=x; return to input1=1 -> out=1 in the same time step.

Source files
------------

// File: rtl/xor_gate.sv
// ---------------------------------------------------------------------------
// xor_gate
//
// Two-input XOR with an optional registered observation path.
//
// The combinational output `out` is a pure XOR of the two operands. It has no
// storage and no clock dependency, so a positional hookup of only the first
// three ports (out, input1, input2) gives a plain 2-input XOR gate.
//
// The registered side watches `out` on every rising clock edge:
//   out_q     - `out` delayed by exactly one cycle
//   toggle_q  - set when `out` differed from `out_q` at the last edge
//   ones_cnt  - saturating count of edges that sampled out = 1
//
// Ports:
//   out       output 1      input1 ^ input2, combinational
//   input1    input  1      first XOR operand
//   input2    input  1      second XOR operand
//   clk       input  1      single clock, rising edge
//   rst_n     input  1      asynchronous, active-low reset of the registers
//   clr       input  1      synchronous clear of ones_cnt (beats increment)
//   out_q     output 1      registered copy of out
//   toggle_q  output 1      registered (out ^ out_q)
//   ones_cnt  output CNT_W  saturating count of edges with out = 1
//
// Parameter:
//   CNT_W     width of ones_cnt, legal range 2..32
// ---------------------------------------------------------------------------
module xor_gate #(
    parameter int CNT_W = 8
) (
    output logic             out,
    input  logic             input1,
    input  logic             input2,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             out_q,
    output logic             toggle_q,
    output logic [CNT_W-1:0] ones_cnt
);

    // All-ones value of the counter; reaching it stops further increments.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_d;
    logic             toggle_d;
    logic [CNT_W-1:0] ones_cnt_d;
    logic [CNT_W-1:0] ones_cnt_q;
    logic             cnt_at_max;

    // A continuous assignment keeps the XOR free of any clock, reset or
    // delay, and lets X/Z on either operand propagate straight to `out`.
    assign out = input1 ^ input2;

    assign cnt_at_max = (ones_cnt_q == CNT_MAX);

    always_comb begin
        out_d      = out;
        // Compares against the current (pre-edge) out_q.
        toggle_d   = out ^ out_q;
        ones_cnt_d = ones_cnt_q;
        if (clr) begin
            ones_cnt_d = '0;
        end else if (out && !cnt_at_max) begin
            ones_cnt_d = ones_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= 1'b0;
            toggle_q   <= 1'b0;
            ones_cnt_q <= '0;
        end else begin
            out_q      <= out_d;
            toggle_q   <= toggle_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign ones_cnt = ones_cnt_q;

endmodule

// File: tb/tb_xor_gate.sv
module tb_xor_gate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       input1 = 1'b0;
    logic       input2 = 1'b0;

    logic       out_a, out_q_a, toggle_q_a;
    logic [7:0] ones_cnt_a;
    logic       out_b, out_q_b, toggle_q_b;
    logic [1:0] ones_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Default-width instance and a narrow instance for saturation.
    xor_gate #(.CNT_W(8)) dut_a (
        .out(out_a), .input1(input1), .input2(input2), .clk(clk),
        .rst_n(rst_n), .clr(clr), .out_q(out_q_a), .toggle_q(toggle_q_a),
        .ones_cnt(ones_cnt_a)
    );

    xor_gate #(.CNT_W(2)) dut_b (
        .out(out_b), .input1(input1), .input2(input2), .clk(clk),
        .rst_n(rst_n), .clr(clr), .out_q(out_q_b), .toggle_q(toggle_q_b),
        .ones_cnt(ones_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // Expected register values from the rules: delayed XOR, change flag,
    // and an integer count clamped at 2^W-1.
    int m_out_q = 0;
    int m_tog   = 0;
    int m_cnt8  = 0;
    int m_cnt2  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_q <= 0;
            m_tog   <= 0;
            m_cnt8  <= 0;
            m_cnt2  <= 0;
        end else begin
            m_out_q <= int'(input1 != input2);
            m_tog   <= int'((input1 != input2) != (m_out_q != 0));
            if (clr) begin
                m_cnt8 <= 0;
                m_cnt2 <= 0;
            end else if (input1 != input2) begin
                m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : m_cnt8;
                m_cnt2 <= (m_cnt2 < 3)   ? m_cnt2 + 1 : m_cnt2;
            end
        end
    end

    // Compare process: every falling edge, all outputs vs the model.
    always @(negedge clk) begin
        check("out_a",      32'(out_a),      32'(input1 != input2));
        check("out_b",      32'(out_b),      32'(input1 != input2));
        check("out_q_a",    32'(out_q_a),    32'(m_out_q));
        check("toggle_q_a", 32'(toggle_q_a), 32'(m_tog));
        check("ones_cnt_a", 32'(ones_cnt_a), 32'(m_cnt8));
        check("out_q_b",    32'(out_q_b),    32'(m_out_q));
        check("toggle_q_b", 32'(toggle_q_b), 32'(m_tog));
        check("ones_cnt_b", 32'(ones_cnt_b), 32'(m_cnt2));
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_in [4];
    logic       tt_exp [4];

    initial begin
        tt_in[0] = 2'b00; tt_exp[0] = 1'b0;
        tt_in[1] = 2'b01; tt_exp[1] = 1'b1;
        tt_in[2] = 2'b10; tt_exp[2] = 1'b1;
        tt_in[3] = 2'b11; tt_exp[3] = 1'b0;

        #1 rst_n = 1'b0;

        // Truth table while registers are held in reset.
        for (int i = 0; i < 4; i++) begin
            input1 = tt_in[i][1];
            input2 = tt_in[i][0];
            #1;
            check("truth_table", 32'(out_a), 32'(tt_exp[i]));
            $display("truth table: in1=%0b in2=%0b out=%0b", input1, input2, out_a);
            #19;
        end
        check("reset_out_q",    32'(out_q_a),    32'd0);
        check("reset_toggle_q", 32'(toggle_q_a), 32'd0);
        check("reset_ones_cnt", 32'(ones_cnt_a), 32'd0);

        // Unknown operand then return to a known value.
        input1 = 1'bx; input2 = 1'b0;
        #1;
        check("x_prop", 32'(out_a), 32'(input1 ^ input2));
        input1 = 1'b1;
        #1;
        check("x_recover", 32'(out_a), 32'd1);
        $display("x handling: out=%0b after input1 returns to 1", out_a);

        // Release reset between edges with out = 1.
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("lat_edge1_out_q",  32'(out_q_a),    32'd1);
        check("lat_edge1_toggle", 32'(toggle_q_a), 32'd1);
        $display("edge 1: out_q=%0b toggle_q=%0b", out_q_a, toggle_q_a);
        tick();
        check("lat_edge2_out_q",  32'(out_q_a),    32'd1);
        check("lat_edge2_toggle", 32'(toggle_q_a), 32'd0);
        $display("edge 2: out_q=%0b toggle_q=%0b", out_q_a, toggle_q_a);
        tick();
        check("sat_edge3_cnt_b", 32'(ones_cnt_b), 32'd3);
        tick();
        tick();
        check("count5_cnt_a", 32'(ones_cnt_a), 32'd5);
        check("sat_edge5_cnt_b", 32'(ones_cnt_b), 32'd3);
        $display("edge 5: ones_cnt_a=%0d ones_cnt_b=%0d", ones_cnt_a, ones_cnt_b);
        tick();
        check("count6_cnt_a", 32'(ones_cnt_a), 32'd6);
        check("sat_edge6_cnt_b", 32'(ones_cnt_b), 32'd3);

        // Clear beats increment while out = 1.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt_a", 32'(ones_cnt_a), 32'd0);
        check("clr_cnt_b", 32'(ones_cnt_b), 32'd0);
        $display("clr pulse: ones_cnt_a=%0d", ones_cnt_a);

        // Build ones_cnt = 4, then drop reset between edges.
        repeat (4) tick();
        check("pre_rst_cnt", 32'(ones_cnt_a), 32'd4);
        check("pre_rst_out_q", 32'(out_q_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_q",  32'(out_q_a),    32'd0);
        check("async_rst_toggle", 32'(toggle_q_a), 32'd0);
        check("async_rst_cnt",    32'(ones_cnt_a), 32'd0);
        check("async_rst_out",    32'(out_a),      32'd1);
        $display("async reset: out_q=%0b toggle_q=%0b ones_cnt=%0d out=%0b",
                 out_q_a, toggle_q_a, ones_cnt_a, out_a);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomised traffic, with occasional clears and mid-run resets.
        for (int i = 0; i < 400; i++) begin
            tick();
            input1 = 1'($urandom);
            input2 = 1'($urandom);
            clr    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        // A long run of ones to exercise saturation of the narrow counter.
        tick();
        clr = 1'b0; input1 = 1'b1; input2 = 1'b0;
        repeat (10) tick();
        check("final_sat_cnt_b", 32'(ones_cnt_b), 32'd3);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
